// File: rtl/busarb.sv
// Two-master bus arbiter: zero-latency grant in IDLE, bus locked to the owner until completion,
// alternating priority. Optional slave-wait watchdog compiled in with `BUSARB_TMO_EN`.
module busarb #(
  parameter int TMO_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_en,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_data_out,
  output logic [31:0] m0_data_in,
  output logic        m0_wt,
  input  logic        m1_en,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_data_out,
  output logic [31:0] m1_data_in,
  output logic        m1_wt,
  output logic        bus_en,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_data_out,
  input  logic [31:0] bus_data_in,
  input  logic        bus_wt
`ifdef BUSARB_TMO_EN
  ,
  output logic        tmo_irq,
  output logic [31:0] tmo_addr
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  if (TMO_CYCLES < 2 || TMO_CYCLES > 65535) begin : g_tmo_range_bad
    $error("busarb: TMO_CYCLES must be in 2..65535");
  end

  state_t      state;
  state_t      state_nxt;
  logic        prio;
  logic        prio_nxt;
  logic        gnt_any;
  logic        gnt_sel;
  logic        active;
  logic        own_wr;
  logic [1:0]  own_size;
  logic [31:0] own_addr;
  logic [31:0] own_data_out;
  logic        own_wt;
  logic [31:0] own_data_in;
  logic        tmo_hit;
  logic        done;

  // Grant selection: IDLE arbitrates combinationally, OWNx pins the grant to its owner.
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = 1'b0;
    case (state)
      IDLE: begin
        if (m0_en && m1_en) begin
          gnt_any = 1'b1;
          gnt_sel = prio;
        end else if (m0_en) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b0;
        end else if (m1_en) begin
          gnt_any = 1'b1;
          gnt_sel = 1'b1;
        end else begin
          gnt_any = 1'b0;
          gnt_sel = 1'b0;
        end
      end
      OWN0: begin
        gnt_any = 1'b1;
        gnt_sel = 1'b0;
      end
      OWN1: begin
        gnt_any = 1'b1;
        gnt_sel = 1'b1;
      end
      default: begin
        gnt_any = 1'b0;
        gnt_sel = 1'b0;
      end
    endcase
  end

  // An owner that has dropped en is treated as no grant at all.
  assign active       = gnt_any && (gnt_sel ? m1_en : m0_en);
  assign own_wr       = gnt_sel ? m1_wr       : m0_wr;
  assign own_size     = gnt_sel ? m1_size     : m0_size;
  assign own_addr     = gnt_sel ? m1_addr     : m0_addr;
  assign own_data_out = gnt_sel ? m1_data_out : m0_data_out;

`ifdef BUSARB_TMO_EN
  logic [15:0] tmo_cnt;
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYCLES - 1);

  assign tmo_hit = active && bus_wt && (tmo_cnt == TMO_LAST);

  // Watchdog counter: runs while the granted transfer is being held off by the slave.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 16'd0;
    end else if (done || !active) begin
      tmo_cnt <= 16'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end
  end

  // Abort report: one-cycle pulse and the address of the aborted transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_irq  <= 1'b0;
      tmo_addr <= 32'h0000_0000;
    end else begin
      tmo_irq <= tmo_hit;
      if (tmo_hit) begin
        tmo_addr <= own_addr;
      end else begin
        tmo_addr <= tmo_addr;
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // A watchdog abort looks like a zero-data completion to the owner.
  assign done        = active && (!bus_wt || tmo_hit);
  assign own_wt      = tmo_hit ? 1'b0 : bus_wt;
  assign own_data_in = tmo_hit ? 32'h0000_0000 : bus_data_in;

  assign bus_en       = active && !tmo_hit;
  assign bus_wr       = active ? own_wr       : 1'b0;
  assign bus_size     = active ? own_size     : 2'd0;
  assign bus_addr     = active ? own_addr     : 32'h0000_0000;
  assign bus_data_out = active ? own_data_out : 32'h0000_0000;

  assign m0_wt      = (active && !gnt_sel) ? own_wt      : 1'b1;
  assign m0_data_in = (active && !gnt_sel) ? own_data_in : 32'h0000_0000;
  assign m1_wt      = (active &&  gnt_sel) ? own_wt      : 1'b1;
  assign m1_data_in = (active &&  gnt_sel) ? own_data_in : 32'h0000_0000;

  // Next state and priority: lock on a waited grant, release on completion or dropped en.
  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    if (done) begin
      prio_nxt = ~gnt_sel;
    end else begin
      prio_nxt = prio;
    end
    case (state)
      IDLE: begin
        if (active && !done) begin
          state_nxt = gnt_sel ? OWN1 : OWN0;
        end else begin
          state_nxt = IDLE;
        end
      end
      OWN0, OWN1: begin
        if (!active || done) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = state;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and priority registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

endmodule

// File: doc/busarb.md
# busarb

Two-master bus arbiter inserted between the bus masters and the single-master bus controller port. It shares the one system bus between master 0 (CPU) and master 1 (DMA/secondary master), locks the bus to the owning master for the duration of a transfer, and alternates priority between the masters. An optional watchdog aborts transfers whose slave never releases its wait signal.

## Interface
- `TMO_CYCLES`, default 256: watchdog limit in cycles of continuous slave wait. Legal range 2..65535. Only used with `BUSARB_TMO_EN`.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `m0_en`, `m0_wr` in 1 each: master 0 request and write flag.
- `m0_size` in 2, `m0_addr` in 32, `m0_data_out` in 32: master 0 transfer attributes.
- `m0_data_in` out 32, `m0_wt` out 1: master 0 read data and wait.
- `m1_en`, `m1_wr`, `m1_size`, `m1_addr`, `m1_data_out`, `m1_data_in`, `m1_wt`: same as master 0, for master 1.
- `bus_en`, `bus_wr` out 1 each, `bus_size` out 2, `bus_addr` out 32, `bus_data_out` out 32: to the bus controller master port.
- `bus_data_in` in 32, `bus_wt` in 1: from the bus controller.
- `tmo_irq` out 1: one-cycle pulse on watchdog abort. Present only with `BUSARB_TMO_EN`.
- `tmo_addr` out 32: address of the last aborted transfer. Present only with `BUSARB_TMO_EN`.

## Operation
- **Bus protocol:** a master holds `en` and its attributes stable until the completion cycle. Completion occurs when `en`=1 and `wt`=0 in the same cycle.
- **States:**
  - IDLE: no transfer in progress.
  - OWN0: master 0 owns the bus.
  - OWN1: master 1 owns the bus.
  - `prio` register: 0 or 1, the master favoured on a conflict.
- **In IDLE, grant is combinational in the request cycle:**
  - Only one master requesting: that master is granted.
  - Both requesting: master `prio` is granted.
  - Neither requesting: `bus_en`=0.
- **In OWNx, the grant is fixed to master x.**
- **Transitions:**
  - IDLE → OWNx when master x is granted and `bus_wt`=1.
  - IDLE stays IDLE when the grant completes in the same cycle.
  - OWNx → IDLE on completion.
- **`prio` update:** on every completion by master x, `prio` is set to 1-x. Alternating service makes starvation impossible when both masters request continuously.
- **Muxing:**
  - The `bus_*` outputs carry the granted master's signals.
  - The granted master receives `bus_data_in` and `bus_wt`.
  - A non-granted master sees `wt`=1 and `data_in`=0.
  - With no grant, `bus_en`=0 and the other `bus_*` outputs are 0.
- **Protocol violation:** if the owning master drops `en` before completion, the arbiter returns to IDLE next edge and `prio` is unchanged.
- **Reset:**
  - State returns to IDLE and `prio`=0.
  - The watchdog counter clears, `tmo_irq`=0 and `tmo_addr`=0.
  - A transfer in flight is discarded and both `m*_wt` follow the IDLE rules.

## Timing
- Zero added latency: an uncontested request reaches `bus_en` in the same cycle, and a 0-wait slave completes in one cycle.
- A losing master waits for the winner's completion cycle. It is granted combinationally in the following cycle, with no idle bubble.
- Back-to-back transfers by the same master with no competitor proceed every cycle.
- All outputs apart from `tmo_irq` and `tmo_addr` are combinational from the inputs and state.
- `tmo_irq` and `tmo_addr` are registered.

## Configuration
- Macro `BUSARB_TMO_EN`, defined: watchdog compiled in.
  - A 16-bit counter increments each cycle that a grant is active and `bus_wt`=1.
  - The counter clears on completion, in IDLE with no request, and on reset.
  - When the counter equals `TMO_CYCLES`-1 and `bus_wt` is still 1, the arbiter forces the owner's `wt`=0 and `data_in`=0. It deasserts `bus_en` in that same cycle, which counts as completion: `prio` updates and the state returns to IDLE.
  - On the next edge, `tmo_irq` pulses for one cycle and `tmo_addr` latches the address.
- `BUSARB_TMO_EN` undefined:
  - No counter is built.
  - `tmo_irq` and `tmo_addr` ports are absent.
  - A stuck slave stalls the owner indefinitely.

## Test plan
- **Lone master 0:** `m0_en`=1, read at 0x20000000, `bus_wt`=0 → `bus_en`=1 in the same cycle, `m0_data_in` = `bus_data_in`, `m0_wt`=0, `m1_wt`=1.
- **Simultaneous requests after reset:** both masters request, slave wait 3 cycles → master 0 is served in cycles 0-3 and master 1 from cycle 4. If both request again afterward, master 0 wins.
- **Lock:**
  - Master 1 owns the bus with `bus_wt`=1 for 5 cycles.
  - Master 0 raises `en` in cycle 2.
  - Required: `bus_addr` remains master 1's address until completion, and master 0 is granted in the following cycle.
- **Continuous contention:** both masters request continuously with 0-wait slaves for 20 cycles → grants alternate 0,1,0,1,…, 10 completions each.
- **Reset mid-transfer:** `rst` is asserted while in OWN1 with `bus_wt`=1 → the state is IDLE immediately and `prio`=0. After release, a pending master 0 request is granted first.
- **Watchdog (`BUSARB_TMO_EN`, `TMO_CYCLES`=4):**
  - Master 0 accesses 0x30F00000 and the slave holds `bus_wt`=1.
  - Required: `m0_wt` falls in cycle 3 with `m0_data_in`=0, `tmo_irq` pulses in cycle 4, and `tmo_addr`=0x30F00000.
